stopwatch_ctrl: RTL

//  Parametrised stopwatch core: conditions raw start/stop/lap buttons, runs IDLE/RUN/PAUSE FSM,

---
 rtl/stopwatch_pkg.sv | 34 +++
 rtl/sw_btn_cond.sv | 78 +++++++
 rtl/stopwatch_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stopwatch_pkg                                              |
// | Description : Shared state encodings, BCD digit width and the per-digit  |
// |               BCD increment helper for the stopwatch core.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package stopwatch_pkg;

  localparam int unsigned c_bcd_w = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } sw_state_e;

  // One BCD digit plus carry-in; returns {carry_out, next_digit}.
  // Any digit >= 9 rolls to 0 with carry so a corrupted digit self-heals.
  function automatic logic [c_bcd_w:0] bcd_inc(input logic [c_bcd_w-1:0] i_digit,
                                               input logic i_cin);
    logic [c_bcd_w:0] res;
    if (!i_cin) begin
      res = {1'b0, i_digit};
    end else if (i_digit >= 4'd9) begin
      res = {1'b1, 4'd0};
    end else begin
      res = {1'b0, i_digit + 4'd1};
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sw_btn_cond.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sw_btn_cond                                                |
// | Description : Raw button conditioner: 2-FF synchroniser, optional        |
// |               debounce filter, rising-edge one-cycle pulse.              |
// |               Debounce filter present when STOPWATCH_DEBOUNCE_EN is      |
// |               defined; otherwise DEB_CYCLES has no effect.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sw_btn_cond #(
  parameter int unsigned DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_level;

  if (DEB_CYCLES < 1) begin : g_deb_cfg_chk
    $error("sw_btn_cond: DEB_CYCLES must be at least 1");
  end

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned c_cnt_w = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

  logic               r_level;
  logic [c_cnt_w-1:0] r_cnt;

  // Accept a new level only after it has been seen DEB_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  assign w_level = r_level;
`else
  assign w_level = r_sync2;
`endif

  // Remember the accepted level so a held button yields a single pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_pulse = w_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stopwatch_ctrl                                             |
// | Description : Stopwatch core: button conditioning, IDLE/RUN/PAUSE FSM,   |
// |               tick prescaler, DIGITS-wide BCD time counter, lap store.   |
// |               Define STOPWATCH_DEBOUNCE_EN to enable button debounce.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1_000_000,
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned LAP_DEPTH  = 4,
  parameter int unsigned DEB_CYCLES = 500_000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_start_btn,
  input  logic                            i_stop_btn,
  input  logic                            i_lap_btn,
  input  logic [$clog2(LAP_DEPTH)-1:0]    i_lap_rd_idx,
  output logic [1:0]                      o_state,
  output logic [4*DIGITS-1:0]             o_time_bcd,
  output logic [4*DIGITS-1:0]             o_lap_bcd,
  output logic [$clog2(LAP_DEPTH):0]      o_lap_count,
  output logic                            o_overflow
);

  localparam int unsigned c_aw = $clog2(LAP_DEPTH);
  localparam int unsigned c_tw = c_bcd_w * DIGITS;
  localparam int unsigned c_pw = $clog2(TICK_DIV);
  localparam logic [c_pw-1:0] c_presc_last = c_pw'(TICK_DIV - 1);
  localparam logic [c_aw:0]   c_lap_full   = (c_aw + 1)'(LAP_DEPTH);

  logic w_start_p;
  logic w_stop_p;
  logic w_lap_p;

  sw_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .clk(clk), .reset(reset), .i_btn(i_start_btn), .o_pulse(w_start_p));
  sw_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_stop (
    .clk(clk), .reset(reset), .i_btn(i_stop_btn), .o_pulse(w_stop_p));
  sw_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_lap (
    .clk(clk), .reset(reset), .i_btn(i_lap_btn), .o_pulse(w_lap_p));

  sw_state_e       r_state;
  logic [c_pw-1:0] r_presc;
  logic [c_tw-1:0] r_time;
  logic            r_overflow;
  logic [c_tw-1:0] r_mem [LAP_DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw:0]   r_lap_count;
  logic [c_tw-1:0] r_lap_bcd;

  logic            w_tick;
  logic [DIGITS:0] w_carry;
  logic [c_tw-1:0] w_time_inc;
  logic            w_lap_we;
  logic            w_full;
  logic [c_aw-1:0] w_rd_base;
  logic [c_aw-1:0] w_rd_addr;

  // Stop dominates every other button; start toggles RUN/PAUSE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else if (w_stop_p) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_start_p) r_state <= ST_RUN;
        ST_RUN:   if (w_start_p) r_state <= ST_PAUSE;
        ST_PAUSE: if (w_start_p) r_state <= ST_RUN;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_tick = (r_state == ST_RUN) && (r_presc == c_presc_last);

  // Prescaler advances only while running; holding in PAUSE keeps the sub-tick phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (w_stop_p || (r_state == ST_IDLE)) begin
      r_presc <= '0;
    end else if (r_state == ST_RUN) begin
      r_presc <= w_tick ? '0 : r_presc + c_pw'(1);
    end
  end

  // Ripple-carry BCD incrementer, digit 0 is the least significant.
  assign w_carry[0] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign {w_carry[gi+1], w_time_inc[c_bcd_w*gi +: c_bcd_w]} =
      bcd_inc(r_time[c_bcd_w*gi +: c_bcd_w], w_carry[gi]);
  end

  // Elapsed time and sticky wrap flag; a carry out of the top digit means all-9s rolled over.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_time     <= '0;
      r_overflow <= 1'b0;
    end else if (w_stop_p) begin
      r_time     <= '0;
      r_overflow <= 1'b0;
    end else if (w_tick) begin
      r_time <= w_time_inc;
      if (w_carry[DIGITS]) r_overflow <= 1'b1;
    end
  end

  assign w_lap_we = w_lap_p && !w_stop_p && (r_state == ST_RUN);
  assign w_full   = (r_lap_count == c_lap_full);

  // Circular lap store; captures the time value before any same-cycle tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAP_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr    <= '0;
      r_lap_count <= '0;
    end else if (w_stop_p) begin
      for (int i = 0; i < LAP_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr    <= '0;
      r_lap_count <= '0;
    end else if (w_lap_we) begin
      r_mem[r_wr_ptr] <= r_time;
      r_wr_ptr        <= r_wr_ptr + c_aw'(1);
      if (!w_full) r_lap_count <= r_lap_count + (c_aw + 1)'(1);
    end
  end

  // Once full, the oldest retained lap sits at the write pointer.
  assign w_rd_base = w_full ? r_wr_ptr : '0;
  assign w_rd_addr = w_rd_base + i_lap_rd_idx;

  // Registered lap read; slots beyond the valid count read as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lap_bcd <= '0;
    end else if (w_stop_p) begin
      r_lap_bcd <= '0;
    end else if ({1'b0, i_lap_rd_idx} < r_lap_count) begin
      r_lap_bcd <= r_mem[w_rd_addr];
    end else begin
      r_lap_bcd <= '0;
    end
  end

  assign o_state     = r_state;
  assign o_time_bcd  = r_time;
  assign o_lap_bcd   = r_lap_bcd;
  assign o_lap_count = r_lap_count;
  assign o_overflow  = r_overflow;

endmodule
`default_nettype wire
